dcp_mem_dump: RTL
=================

Name: dcp_mem_dump

Overview:
Parametrised memory-dump engine for the debug control panel, the next generation of the single-memory data-dump child. One instance serves NCH memories, each selected by its own command character (default 'I' instruction memory, 'D' data memory). It reads an optional hex start address through the scan handshake and reads NWORDS consecutive words from the selected memory. It prints one line per word, "addr:data\n", through the print handshake, then pulses finish. Remembers a per-channel continuation address, so a bare Enter continues the previous dump.

Parameters:
NCH, 2, number of memory channels
CH_CODES, {8'h49,8'h44}, packed NCH x 8-bit command codes; channel k = CH_CODES[8k+7:8k] (ch0='D', ch1='I')
NWORDS, 8, words printed per command (>=1)
ADDR_STEP, 1, address increment per word (word-addressed memories)
RD_LAT, 1, cycles from addr change to valid dout (0..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sel_mode  in  8  current command from top-level dispatcher
ack_rx  in  1  scan done pulse (1 cycle)
flag_rx  in  1  with ack_rx: 1 = no argument entered (bare Enter)
din_rx  in  32  scanned hex word, valid with ack_rx
req_rx  out  1  scan request
type_rx  out  1  scan type: 1 = hex word, 0 = single char
ack_tx  in  1  print done pulse (1 cycle)
req_tx  out  1  print request
type_tx  out  1  1 = 8-digit hex word, 0 = single char dout_tx[7:0]
dout_tx  out  32  print payload
addr  out  32  memory address to selected channel
dout_mem  in  32*NCH  read data, channel k at [32k+31:32k]
finish  out  1  high for exactly 1 cycle when command complete

Behaviour:
- Reset (rst=0, async): state IDLE; req_rx, type_rx, req_tx, type_tx, finish = 0; dout_tx, addr = 0; all continuation addresses = 0.
- Channel match: sel_mode equal to CH_CODES[k] -> ch=k (lowest k wins on duplicates). No match -> stay IDLE, all outputs 0.
- States:
  IDLE: on match, latch ch -> REQ_ARG.
  REQ_ARG: req_rx=1, type_rx=1 until ack_rx. On ack_rx: if flag_rx, base = cont[ch]; else base = din_rx. Set addr=base, cnt=0, req_rx=0 next cycle -> RD_WAIT.
  RD_WAIT: count RD_LAT cycles (0 = skip), capture dout_mem[ch] into data reg -> TX_ADDR.
  TX_ADDR: req_tx=1, type_tx=1, dout_tx=addr until ack_tx -> TX_COLON.
  TX_COLON: type_tx=0, dout_tx=32'h3A -> TX_DATA.
  TX_DATA: type_tx=1, dout_tx=data reg -> TX_NL.
  TX_NL: type_tx=0, dout_tx=32'h0A -> NEXT.
  NEXT: addr += ADDR_STEP (mod 2^32, wraps FFFF_FFFF->0); cnt++; if cnt==NWORDS-1 before increment, cont[ch] = incremented addr -> DONE; else -> RD_WAIT.
  DONE: finish=1 for one cycle -> HOLD.
  HOLD: outputs 0; return to IDLE when sel_mode no longer matches ch (no re-trigger while dispatcher still selects this mode).
- Handshake: req_* asserted from state entry; the cycle after ack_* req_* is 0 for at least one cycle before the next request. Payload and type remain stable while req_* is high. ack without req ignored.
- sel_mode leaving ch mid-command (not IDLE/HOLD): abort to IDLE next cycle, drop requests, no finish, cont[ch] unchanged.
- ack_rx and ack_tx arriving together: only the one matching the current state is honoured.
- addr is held constant from RD_WAIT entry to NEXT; memories are read only.

Decomposition:
- Shared package dcp_pkg: command character constants (CMD_D=8'h44, CMD_I=8'h49, ...), print char constants (CHR_COLON=8'h3A, CHR_NL=8'h0A), print/scan type encodings, state enum.
- One natural sub-module: dcp_hs_req (request/ack handshake holder with post-ack gap), instanced for scan and print.

Test Plan:
- Reset, then sel_mode=8'h44, ack_rx with din_rx=0x10, flag_rx=0, NWORDS=2, mem[0x10]=0xDEADBEEF, mem[0x11]=0x12345678 -> prints 0x10,':',DEADBEEF,'\n',0x11,':',12345678,'\n'; finish one pulse; cont[0]=0x12.
- Repeat 'D' with flag_rx=1 -> dump starts at 0x12; 'I' with flag_rx=1 starts at 0 (independent channels).
- din_rx=0xFFFFFFFF, NWORDS=2 -> second line addr 0x00000000.
- RD_LAT=3, memory changes data 2 cycles after addr -> printed value is the post-latency data.
- sel_mode forced to 8'h00 during TX_DATA -> req_tx drops next cycle, no finish, rerun resumes from old cont.
- ack_tx held off 50 cycles -> req_tx, type_tx, dout_tx stable throughout; rst low mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared command/print constants and the dump state encoding for the debug
// control panel children.
package dcp_pkg;

  localparam logic [7:0] CMD_D     = 8'h44;
  localparam logic [7:0] CMD_I     = 8'h49;
  localparam logic [7:0] CHR_COLON = 8'h3A;
  localparam logic [7:0] CHR_NL    = 8'h0A;

  localparam logic TYPE_CHAR = 1'b0;
  localparam logic TYPE_HEX  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ_ARG,
    ST_RD_WAIT,
    ST_TX_ADDR,
    ST_TX_COLON,
    ST_TX_DATA,
    ST_TX_NL,
    ST_NEXT,
    ST_DONE,
    ST_HOLD
  } dump_state_e;

  function automatic logic is_tx_state(input dump_state_e s);
    return (s == ST_TX_ADDR) || (s == ST_TX_COLON) || (s == ST_TX_DATA) || (s == ST_TX_NL);
  endfunction

endpackage

// File: rtl/dcp_hs_req.sv
// Request holder for the scan/print handshakes: req follows the caller's next-state
// intent, drops on the acknowledged edge and stays low at least one cycle after.
module dcp_hs_req (
  input  logic clk,
  input  logic rst,
  input  logic want,
  input  logic ack,
  output logic req,
  output logic done
);

  logic req_q, req_d;

  // An ack only counts while a request is actually outstanding.
  assign done = req_q && ack;

  always_comb begin
    req_d = want && !done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/dcp_mem_dump.sv
// Multi-channel memory dump: scans an optional start address, prints NWORDS
// "addr:data\n" lines from the selected memory and keeps a per-channel resume address.
module dcp_mem_dump
  import dcp_pkg::*;
#(
  parameter int              NCH       = 2,
  parameter logic [8*NCH-1:0] CH_CODES = {CMD_I, CMD_D},
  parameter int              NWORDS    = 8,
  parameter int              ADDR_STEP = 1,
  parameter int              RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        sel_mode,
  input  logic              ack_rx,
  input  logic              flag_rx,
  input  logic [31:0]       din_rx,
  output logic              req_rx,
  output logic              type_rx,
  input  logic              ack_tx,
  output logic              req_tx,
  output logic              type_tx,
  output logic [31:0]       dout_tx,
  output logic [31:0]       addr,
  input  logic [32*NCH-1:0] dout_mem,
  output logic              finish
);

  localparam int          CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0]  LAT  = 2'(RD_LAT);
  localparam logic [31:0] LAST = 32'(NWORDS - 1);
  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  logic [7:0]  code   [NCH];
  logic [31:0] mem_rd [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign code[gi]   = CH_CODES[8*gi +: 8];
    assign mem_rd[gi] = dout_mem[32*gi +: 32];
  end

  dump_state_e state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [1:0]     lat_q, lat_d;
  logic [31:0]    cont_q [NCH];
  logic [31:0]    cont_d [NCH];
  logic           type_rx_q, type_rx_d;
  logic           type_tx_q, type_tx_d;
  logic [31:0]    dout_tx_q, dout_tx_d;
  logic           finish_q, finish_d;

  logic           match;
  logic [CHW-1:0] match_ch;
  logic           sel_hit;
  logic [31:0]    addr_inc;
  logic           rx_want, rx_done, tx_want, tx_done;

  // Scanning downwards lets the lowest matching channel win on duplicate codes.
  always_comb begin
    match    = 1'b0;
    match_ch = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (sel_mode == code[k]) begin
        match    = 1'b1;
        match_ch = CHW'(k);
      end
    end
  end

  assign sel_hit  = (sel_mode == code[ch_q]);
  assign addr_inc = addr_q + STEP;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    cont_d  = cont_q;

    case (state_q)
      ST_IDLE: begin
        if (match) begin
          ch_d    = match_ch;
          state_d = ST_REQ_ARG;
        end
      end
      ST_REQ_ARG: begin
        if (rx_done) begin
          addr_d  = flag_rx ? cont_q[ch_q] : din_rx;
          cnt_d   = '0;
          lat_d   = '0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT) begin
          data_d  = mem_rd[ch_q];
          state_d = ST_TX_ADDR;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_TX_ADDR:  if (tx_done) state_d = ST_TX_COLON;
      ST_TX_COLON: if (tx_done) state_d = ST_TX_DATA;
      ST_TX_DATA:  if (tx_done) state_d = ST_TX_NL;
      ST_TX_NL:    if (tx_done) state_d = ST_NEXT;
      ST_NEXT: begin
        addr_d = addr_inc;
        cnt_d  = cnt_q + 32'd1;
        lat_d  = '0;
        if (cnt_q == LAST) begin
          cont_d[ch_q] = addr_inc;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: if (!sel_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Dispatcher moved away mid-command: abandon silently, keep the resume address.
    if (state_q != ST_IDLE && state_q != ST_HOLD && !sel_hit) begin
      state_d = ST_IDLE;
      cont_d  = cont_q;
    end

    if (state_d == ST_IDLE || state_d == ST_HOLD) begin
      addr_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with state entry.
  always_comb begin
    rx_want   = (state_d == ST_REQ_ARG);
    tx_want   = is_tx_state(state_d);
    type_rx_d = rx_want;
    type_tx_d = TYPE_CHAR;
    dout_tx_d = '0;
    finish_d  = (state_d == ST_DONE);
    case (state_d)
      ST_TX_ADDR: begin
        type_tx_d = TYPE_HEX;
        dout_tx_d = addr_d;
      end
      ST_TX_COLON: dout_tx_d = {24'd0, CHR_COLON};
      ST_TX_DATA: begin
        type_tx_d = TYPE_HEX;
        dout_tx_d = data_d;
      end
      ST_TX_NL: dout_tx_d = {24'd0, CHR_NL};
      default: ;
    endcase
  end

  dcp_hs_req u_hs_rx (
    .clk  (clk),
    .rst  (rst),
    .want (rx_want),
    .ack  (ack_rx),
    .req  (req_rx),
    .done (rx_done)
  );

  dcp_hs_req u_hs_tx (
    .clk  (clk),
    .rst  (rst),
    .want (tx_want),
    .ack  (ack_tx),
    .req  (req_tx),
    .done (tx_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      type_rx_q <= 1'b0;
      type_tx_q <= 1'b0;
      dout_tx_q <= '0;
      finish_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        cont_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      type_rx_q <= type_rx_d;
      type_tx_q <= type_tx_d;
      dout_tx_q <= dout_tx_d;
      finish_q  <= finish_d;
      for (int k = 0; k < NCH; k++) begin
        cont_q[k] <= cont_d[k];
      end
    end
  end

  assign type_rx = type_rx_q;
  assign type_tx = type_tx_q;
  assign dout_tx = dout_tx_q;
  assign addr    = addr_q;
  assign finish  = finish_q;

endmodule
